// File: rtl/alu_nibble_seq.sv
// Nibble-serial ALU sequencer: one 8-bit op per request, low nibble then high
// nibble through a shared 4-bit datapath, result and {Z,N,H,C} on a valid/ready channel.
module alu_nibble_seq (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_op,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   input  logic       in_cin,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_r,
   output logic [3:0] out_flags
);

   typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_ADC = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_SBC = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_OR  = 3'd6;
   localparam logic [2:0] OP_NEG = 3'd7;

   state_t     state_r, state_s;
   logic [2:0] op_r;
   logic [7:0] a_r, b_r;
   logic       cin_r, half_r;
   logic [3:0] lo_r;
   logic [7:0] res_r;
   logic [3:0] flags_r;
   logic       valid_r;

   logic       accept_s;
   logic [3:0] x_s, y_s;
   logic       ci_s;
   logic [4:0] nib_s;
   logic       arith_s, sub_s;
   logic [7:0] full_s;
   logic [3:0] flags_s;

   assign in_ready  = (state_r == IDLE) | ((state_r == DONE) & out_ready);
   assign accept_s  = in_valid & in_ready;
   assign out_valid = valid_r;
   assign out_r     = res_r;
   assign out_flags = flags_r;

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = LO;
            else          state_s = IDLE;
         end
         LO:   state_s = HI;
         HI:   state_s = DONE;
         DONE: begin
            if (out_ready) state_s = accept_s ? LO : IDLE;
            else           state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // Shared 4-bit datapath; HI chains only from the latched half-carry
   always_comb begin
      sub_s   = (op_r == OP_SUB) | (op_r == OP_SBC) | (op_r == OP_NEG);
      arith_s = sub_s | (op_r == OP_ADD) | (op_r == OP_ADC);
      if (state_r == HI) begin
         x_s  = a_r[7:4];
         y_s  = b_r[7:4];
         ci_s = half_r;
      end else begin
         x_s  = a_r[3:0];
         y_s  = b_r[3:0];
         ci_s = ((op_r == OP_ADC) | (op_r == OP_SBC)) ? cin_r : 1'b0;
      end
      if (op_r == OP_NEG) begin
         x_s = 4'd0;
      end else begin
         x_s = x_s;
      end
      case (op_r)
         OP_ADD, OP_ADC:         nib_s = {1'b0, x_s} + {1'b0, y_s} + {4'd0, ci_s};
         OP_SUB, OP_SBC, OP_NEG: nib_s = {1'b0, x_s} - {1'b0, y_s} - {4'd0, ci_s};
         OP_AND:                 nib_s = {1'b0, x_s & y_s};
         OP_XOR:                 nib_s = {1'b0, x_s ^ y_s};
         OP_OR:                  nib_s = {1'b0, x_s | y_s};
         default:                nib_s = 5'd0;
      endcase
      full_s  = {nib_s[3:0], lo_r};
      flags_s = {(full_s == 8'h00), sub_s,
                 arith_s ? half_r : (op_r == OP_AND),
                 arith_s ? nib_s[4] : 1'b0};
   end

   // State, operand capture and result/flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         op_r    <= 3'd0;
         a_r     <= 8'h00;
         b_r     <= 8'h00;
         cin_r   <= 1'b0;
         half_r  <= 1'b0;
         lo_r    <= 4'h0;
         res_r   <= 8'h00;
         flags_r <= 4'h0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_s;
         valid_r <= (state_s == DONE);
         if (accept_s) begin
            op_r  <= in_op;
            a_r   <= in_a;
            b_r   <= in_b;
            cin_r <= in_cin;
         end
         if (state_r == LO) begin
            lo_r   <= nib_s[3:0];
            half_r <= nib_s[4];
         end
         if (state_r == HI) begin
            res_r   <= full_s;
            flags_r <= flags_s;
         end
      end
   end

endmodule
